// File: rtl/ocl_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ocl_axil_arbiter
//  Purpose  : Round-robin arbiter sharing one AXI-Lite master port (towards
//             the OCL register slave) between NUM_REQ single-beat requesters.
//             Only one AXI-Lite transaction is ever outstanding.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_main_a0, rst_main_n      : clock, asynchronous active-low reset
//    req_valid/req_we/req_addr/
//    req_wdata/req_wstrb          : per-requester request (packed vectors)
//    req_ready                    : one-hot, one-cycle grant pulse
//    rsp_valid/rsp_rdata/rsp_resp : one-hot, one-cycle response pulse + data
//    m_aw*/m_w*/m_b*/m_ar*/m_r*   : AXI-Lite master channels
// ============================================================================
module ocl_axil_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32
) (
    input  logic                      clk_main_a0,
    input  logic                      rst_main_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_wstrb,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      m_awvalid,
    output logic [ADDR_W-1:0]         m_awaddr,
    input  logic                      m_awready,
    output logic                      m_wvalid,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic                      m_arvalid,
    output logic [ADDR_W-1:0]         m_araddr,
    input  logic                      m_arready,
    input  logic                      m_rvalid,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    output logic                      m_rready
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR      = 3'd1;
    localparam logic [2:0] c_ST_WR_RESP = 3'd2;
    localparam logic [2:0] c_ST_RD_ADDR = 3'd3;
    localparam logic [2:0] c_ST_RD_RESP = 3'd4;
    localparam logic [2:0] c_ST_RESP    = 3'd5;

    logic [2:0]         r_state,     w_state_nxt;
    logic [c_IDX_W-1:0] r_ptr,       w_ptr_nxt;
    logic [c_IDX_W-1:0] r_gidx,      w_gidx_nxt;
    logic [ADDR_W-1:0]  r_addr,      w_addr_nxt;
    logic [31:0]        r_wdata,     w_wdata_nxt;
    logic [3:0]         r_wstrb,     w_wstrb_nxt;
    logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
    logic [NUM_REQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]        r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]         r_rsp_resp,  w_rsp_resp_nxt;
    logic [31:0]        r_cap_rdata, w_cap_rdata_nxt;
    logic [1:0]         r_cap_resp,  w_cap_resp_nxt;
    logic               r_awvalid,   w_awvalid_nxt;
    logic               r_wvalid,    w_wvalid_nxt;
    logic               r_aw_done,   w_aw_done_nxt;
    logic               r_w_done,    w_w_done_nxt;
    logic               r_bready,    w_bready_nxt;
    logic               r_arvalid,   w_arvalid_nxt;
    logic               r_rready,    w_rready_nxt;

    logic               w_found;
    logic [c_IDX_W-1:0] w_gidx;
    logic [c_IDX_W-1:0] w_ptr_adv;
    logic               w_aw_ok;
    logic               w_w_ok;

    // Round-robin search: first valid requester at or above the pointer.
    always_comb begin
        int v_k;
        int v_n;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_k = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_found && req_valid[c_IDX_W'(v_k)]) begin
                w_found = 1'b1;
                w_gidx  = c_IDX_W'(v_k);
            end
        end
        v_n = int'(w_gidx) + 1;
        if (v_n >= NUM_REQ) begin
            v_n = 0;
        end
        w_ptr_adv = c_IDX_W'(v_n);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gidx_nxt      = r_gidx;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_cap_rdata_nxt = r_cap_rdata;
        w_cap_resp_nxt  = r_cap_resp;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_aw_ok         = r_aw_done | (r_awvalid & m_awready);
        w_w_ok          = r_w_done  | (r_wvalid  & m_wready);

        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_gidx_nxt      = w_gidx;
                    w_ptr_nxt       = w_ptr_adv;
                    w_req_ready_nxt = c_ONE << w_gidx;
                    w_addr_nxt      = req_addr[w_gidx*ADDR_W +: ADDR_W];
                    w_wdata_nxt     = req_wdata[w_gidx*32 +: 32];
                    w_wstrb_nxt     = req_wstrb[w_gidx*4 +: 4];
                    w_aw_done_nxt   = 1'b0;
                    w_w_done_nxt    = 1'b0;
                    w_state_nxt     = req_we[w_gidx] ? c_ST_WR : c_ST_RD_ADDR;
                end
            end
            c_ST_WR: begin
                // The grant-pulse cycle doubles as the set-up cycle, so the
                // channel valids appear one cycle after req_ready.
                if (|r_req_ready) begin
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                end else begin
                    if (r_awvalid && m_awready) begin
                        w_awvalid_nxt = 1'b0;
                    end
                    if (r_wvalid && m_wready) begin
                        w_wvalid_nxt = 1'b0;
                    end
                    w_aw_done_nxt = w_aw_ok;
                    w_w_done_nxt  = w_w_ok;
                    if (w_aw_ok && w_w_ok) begin
                        w_bready_nxt = 1'b1;
                        w_state_nxt  = c_ST_WR_RESP;
                    end
                end
            end
            c_ST_WR_RESP: begin
                if (m_bvalid) begin
                    w_cap_resp_nxt  = m_bresp;
                    w_cap_rdata_nxt = '0;
                    w_bready_nxt    = 1'b0;
                    w_state_nxt     = c_ST_RESP;
                end
            end
            c_ST_RD_ADDR: begin
                if (|r_req_ready) begin
                    w_arvalid_nxt = 1'b1;
                end else if (r_arvalid && m_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = c_ST_RD_RESP;
                end
            end
            c_ST_RD_RESP: begin
                if (m_rvalid) begin
                    w_cap_rdata_nxt = m_rdata;
                    w_cap_resp_nxt  = m_rresp;
                    w_rready_nxt    = 1'b0;
                    w_state_nxt     = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                // Response data is only loaded here so it holds steady
                // between responses.
                w_rsp_valid_nxt = c_ONE << r_gidx;
                w_rsp_rdata_nxt = r_cap_rdata;
                w_rsp_resp_nxt  = r_cap_resp;
                w_state_nxt     = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_cap_rdata <= '0;
            r_cap_resp  <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gidx      <= w_gidx_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_cap_rdata <= w_cap_rdata_nxt;
            r_cap_resp  <= w_cap_resp_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign m_awvalid = r_awvalid;
    assign m_awaddr  = r_addr;
    assign m_wvalid  = r_wvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_bready  = r_bready;
    assign m_arvalid = r_arvalid;
    assign m_araddr  = r_addr;
    assign m_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_ocl_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ocl_axil_arbiter
//  Purpose  : Self-checking bench for ocl_axil_arbiter with an AXI-Lite slave
//             model and a round-robin reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ocl_axil_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;

    logic                      clk_main_a0 = 1'b0;
    logic                      rst_main_n  = 1'b0;
    logic [NUM_REQ-1:0]        req_valid   = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we      = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr    = '0;
    logic [NUM_REQ*32-1:0]     req_wdata   = '0;
    logic [NUM_REQ*4-1:0]      req_wstrb   = '0;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [31:0]               rsp_rdata;
    logic [1:0]                rsp_resp;
    logic                      m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [ADDR_W-1:0]         m_awaddr, m_araddr;
    logic [31:0]               m_wdata;
    logic [3:0]                m_wstrb;
    logic                      m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic                      m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]                m_bresp = '0, m_rresp = '0;
    logic [31:0]               m_rdata = '0;

    ocl_axil_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) u_dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
    );

    initial forever #5 clk_main_a0 = ~clk_main_a0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Register contents the slave model returns for a read address.
    function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- AXI-Lite slave model + channel protocol monitor -------
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
    logic aw_got, w_got, ar_got, b_hs, r_hs;
    logic p_aw_wait, p_w_wait, p_ar_wait, p_aw_hs, p_w_hs, p_ar_hs;
    logic [ADDR_W-1:0] p_awaddr, p_araddr, last_awaddr = '0, last_araddr = '0;
    logic [31:0] p_wdata, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    initial forever begin
        @(negedge clk_main_a0);
        if (!rst_main_n) begin
            m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            m_bresp = 0; m_rresp = 0; m_rdata = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0; p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0;
        end else begin
            // valids must hold with stable payload until accepted, then drop
            if (p_aw_wait) begin
                chk("aw_hold", 32'(m_awvalid), 32'd1);
                chk("aw_addr_stable", m_awaddr, p_awaddr);
            end
            if (p_w_wait) begin
                chk("w_hold", 32'(m_wvalid), 32'd1);
                chk("w_data_stable", m_wdata, p_wdata);
            end
            if (p_ar_wait) begin
                chk("ar_hold", 32'(m_arvalid), 32'd1);
                chk("ar_addr_stable", m_araddr, p_araddr);
            end
            if (p_aw_hs) chk("aw_drop", 32'(m_awvalid), 32'd0);
            if (p_w_hs)  chk("w_drop",  32'(m_wvalid),  32'd0);
            if (p_ar_hs) chk("ar_drop", 32'(m_arvalid), 32'd0);
            if (b_hs) begin m_bvalid = 0; b_hs = 0; aw_got = 0; w_got = 0; end
            if (r_hs) begin m_rvalid = 0; r_hs = 0; ar_got = 0; end
            if (aw_got && w_got && !b_hs) begin
                if (b_cnt >= b_dly) begin
                    m_bvalid = 1; m_bresp = bresp_cfg;
                    if (m_bready) begin b_hs = 1; b_hs_cnt++; b_cnt = 0; end
                end else b_cnt++;
            end
            if (ar_got && !r_hs) begin
                if (r_cnt >= r_dly) begin
                    m_rvalid = 1; m_rresp = rresp_cfg;
                    m_rdata  = ovr_en ? ovr_data : mem_fn(last_araddr);
                    if (m_rready) begin r_hs = 1; r_hs_cnt++; r_cnt = 0; end
                end else r_cnt++;
            end
            m_awready = 0; m_wready = 0; m_arready = 0;
            if (m_awvalid && !aw_got) begin
                if (aw_cnt >= aw_dly) begin
                    m_awready = 1; aw_got = 1; aw_cnt = 0; aw_hs_cnt++; last_awaddr = m_awaddr;
                end else aw_cnt++;
            end
            if (m_wvalid && !w_got) begin
                if (w_cnt >= w_dly) begin
                    m_wready = 1; w_got = 1; w_cnt = 0; w_hs_cnt++;
                    last_wdata = m_wdata; last_wstrb = m_wstrb;
                end else w_cnt++;
            end
            if (m_arvalid && !ar_got) begin
                if (ar_cnt >= ar_dly) begin
                    m_arready = 1; ar_got = 1; ar_cnt = 0; ar_hs_cnt++; last_araddr = m_araddr;
                end else ar_cnt++;
            end
            p_aw_wait = m_awvalid && !m_awready; p_aw_hs = m_awvalid && m_awready;
            p_w_wait  = m_wvalid  && !m_wready;  p_w_hs  = m_wvalid  && m_wready;
            p_ar_wait = m_arvalid && !m_arready; p_ar_hs = m_arvalid && m_arready;
            p_awaddr = m_awaddr; p_wdata = m_wdata; p_araddr = m_araddr;
        end
    end

    // ---------------- requester side + round-robin reference model ----------
    int model_ptr = 0;
    logic [ADDR_W-1:0] t_addr  [NUM_REQ];
    logic [31:0]       t_wdata [NUM_REQ];
    logic [3:0]        t_wstrb [NUM_REQ];
    logic              t_we    [NUM_REQ];

    task automatic post(input int r, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        t_we[r] = we; t_addr[r] = a; t_wdata[r] = d; t_wstrb[r] = s;
        req_we[r] = we;
        req_addr[r*ADDR_W +: ADDR_W] = a;
        req_wdata[r*32 +: 32] = d;
        req_wstrb[r*4 +: 4] = s;
        req_valid[r] = 1'b1;
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_flags"}, 32'({req_ready, rsp_valid, m_awvalid, m_wvalid,
                                   m_bready, m_arvalid, m_rready}), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_resp"}, 32'(rsp_resp), 32'd0);
        chk({tag, "_addr"}, m_awaddr, 32'd0);
    endtask

    task automatic serve_one();
        int g, n;
        int aw0, w0, b0, ar0, r0;
        logic [NUM_REQ-1:0] exp_oh;
        logic [31:0] exp_rd;
        g = exp_grant();
        exp_oh = '0; exp_oh[g] = 1'b1;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; ar0 = ar_hs_cnt; r0 = r_hs_cnt;
        n = 0;
        while (req_ready == '0 && n < 50) begin @(negedge clk_main_a0); n++; end
        chk("grant", 32'(req_ready), 32'(exp_oh));
        req_valid[g] = 1'b0;
        model_ptr = (g + 1) % NUM_REQ;
        n = 0;
        do begin @(negedge clk_main_a0); n++; end while (rsp_valid == '0 && n < 300);
        exp_rd = t_we[g] ? 32'd0 : (ovr_en ? ovr_data : mem_fn(t_addr[g]));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_resp", 32'(rsp_resp), 32'(t_we[g] ? bresp_cfg : rresp_cfg));
        if (t_we[g]) begin
            chk("aw_hs_count", 32'(aw_hs_cnt - aw0), 32'd1);
            chk("w_hs_count",  32'(w_hs_cnt - w0),   32'd1);
            chk("b_hs_count",  32'(b_hs_cnt - b0),   32'd1);
            chk("awaddr", last_awaddr, t_addr[g]);
            chk("wdata",  last_wdata,  t_wdata[g]);
            chk("wstrb",  32'(last_wstrb), 32'(t_wstrb[g]));
        end else begin
            chk("ar_hs_count", 32'(ar_hs_cnt - ar0), 32'd1);
            chk("r_hs_count",  32'(r_hs_cnt - r0),   32'd1);
            chk("araddr", last_araddr, t_addr[g]);
        end
        @(negedge clk_main_a0);
        chk("rsp_pulse_len", 32'(rsp_valid), 32'd0);
    endtask

    task automatic serve_all();
        while (req_valid != '0) serve_one();
    endtask

    task automatic do_reset();
        @(negedge clk_main_a0);
        rst_main_n = 1'b0;
        repeat (3) @(negedge clk_main_a0);
        rst_main_n = 1'b1;
        model_ptr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] mask;
        repeat (3) @(negedge clk_main_a0);
        check_outputs_zero("reset");
        rst_main_n = 1'b1;
        @(negedge clk_main_a0);

        // 1: single write, zero-wait slave, exact cycle timing
        post(0, 1'b1, 32'h500, 32'h1234_5678, 4'hF);
        @(negedge clk_main_a0);
        chk("t1_ready", 32'(req_ready), 32'd1);
        chk("t1_aw_not_yet", 32'(m_awvalid), 32'd0);
        req_valid[0] = 1'b0; model_ptr = 1;
        @(negedge clk_main_a0);
        chk("t1_aw_w_valid", 32'({m_awvalid, m_wvalid}), 32'd3);
        chk("t1_awaddr", m_awaddr, 32'h500);
        chk("t1_wdata", m_wdata, 32'h1234_5678);
        chk("t1_wstrb", 32'(m_wstrb), 32'hF);
        @(negedge clk_main_a0);
        chk("t1_bready", 32'({m_awvalid, m_wvalid, m_bready}), 32'd1);
        @(negedge clk_main_a0);
        chk("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk_main_a0);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_rdata", rsp_rdata, 32'd0);
        chk("t1_rsp_resp", 32'(rsp_resp), 32'd0);
        @(negedge clk_main_a0);

        // 2: simultaneous reads, pointer restarted by reset
        do_reset();
        for (int k = 0; k < 2; k++) begin
            post(0, 1'b0, 32'h100 + 32'(k * 8), 32'd0, 4'h0);
            post(1, 1'b0, 32'h200 + 32'(k * 8), 32'd0, 4'h0);
            serve_all();
        end

        // 3: AW/W handshakes in both orders
        aw_dly = 0; w_dly = 3;
        post(1, 1'b1, 32'h340, 32'hA5A5_0001, 4'h3);
        serve_all();
        aw_dly = 3; w_dly = 0;
        post(0, 1'b1, 32'h344, 32'h5A5A_0002, 4'hC);
        serve_all();
        aw_dly = 0;

        // 4: read with error response and fixed data
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; rresp_cfg = 2'b10;
        post(1, 1'b0, 32'h504, 32'd0, 4'h0);
        serve_all();
        ovr_en = 1'b0; rresp_cfg = 2'b00;

        // 5: reset while waiting for the write response, req1 pending
        b_dly = 30;
        post(0, 1'b1, 32'h600, 32'hCAFE_0005, 4'hF);
        n = 0;
        while (req_ready == '0 && n < 50) begin @(negedge clk_main_a0); n++; end
        chk("t5_grant", 32'(req_ready), 32'd1);
        req_valid[0] = 1'b0;
        post(1, 1'b0, 32'h700, 32'd0, 4'h0);
        n = 0;
        while (!m_bready && n < 50) begin @(negedge clk_main_a0); n++; end
        chk("t5_in_wr_resp", 32'(m_bready), 32'd1);
        rst_main_n = 1'b0;
        #1;
        check_outputs_zero("t5_async_reset");
        b_dly = 0;
        repeat (3) begin
            @(negedge clk_main_a0);
            chk("t5_quiet_in_reset", 32'(rsp_valid), 32'd0);
        end
        rst_main_n = 1'b1;
        model_ptr = 0;
        serve_all();

        // randomized batches against the reference model
        for (int it = 0; it < 30; it++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
            mask = 2'($urandom_range(1, 3));
            for (int r = 0; r < NUM_REQ; r++) begin
                if (mask[r]) post(r, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                                  $urandom, 4'($urandom_range(0, 15)));
            end
            serve_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ocl_axil_arbiter.md
Name: ocl_axil_arbiter

Overview:
- Round-robin arbiter that shares the single OCL AXI-Lite register slave (downstream of the OCL register slice) between NUM_REQ internal requesters, e.g. host-mirror logic and debug/VIO-driven register pokes.
- Each requester uses a simple single-beat request/response bus.
- The block sequences exactly one AXI-Lite transaction at a time on the master side.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width

Ports:
clk_main_a0  in  1  main clock
rst_main_n  in  1  reset, asynchronous assert, active-low
req_valid  in  NUM_REQ  per-requester request valid; held until req_ready
req_ready  out  NUM_REQ  one-hot grant pulse, 1 cycle
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses
req_wdata  in  NUM_REQ*32  packed write data
req_wstrb  in  NUM_REQ*4  packed byte strobes
rsp_valid  out  NUM_REQ  one-hot response pulse to granted requester, 1 cycle, no backpressure
rsp_rdata  out  32  read data (0 for writes)
rsp_resp  out  2  AXI response code
m_awvalid  out  1  master write address valid
m_awaddr  out  ADDR_W  write address
m_awready  in  1  write address ready
m_wvalid  out  1  write data valid
m_wdata  out  32  write data
m_wstrb  out  4  write strobes
m_wready  in  1  write data ready
m_bvalid  in  1  write response valid
m_bresp  in  2  write response
m_bready  out  1  write response ready
m_arvalid  out  1  read address valid
m_araddr  out  ADDR_W  read address
m_arready  in  1  read address ready
m_rvalid  in  1  read data valid
m_rdata  in  32  read data
m_rresp  in  2  read response
m_rready  out  1  read data ready

Behaviour:
- Reset (async, rst_main_n=0): state=IDLE, rr pointer=0, all outputs 0.
  - Any in-flight transaction is abandoned; no rsp_valid is issued for it.
  - Deassertion takes effect on the next clk_main_a0 edge.
- All outputs are registered.
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_RESP, RESP.
- IDLE, arbitration:
  - If any req_valid, grant the first set bit searching from pointer upward, modulo NUM_REQ.
  - Next cycle: req_ready[grant]=1 for exactly 1 cycle, and addr/wdata/wstrb/we are latched.
  - pointer <= (grant+1) mod NUM_REQ.
  - Next state: WR if we=1, else RD_ADDR.
- WR:
  - m_awvalid and m_wvalid assert together.
  - Each deasserts independently on its own handshake (valid&ready).
  - Both may complete in the same cycle or in either order.
  - Move to WR_RESP once both have completed.
- WR_RESP: m_bready=1; on m_bvalid, capture m_bresp, set rdata=0, go to RESP.
- RD_ADDR: m_arvalid=1 until m_arready, then go to RD_RESP.
- RD_RESP: m_rready=1; on m_rvalid, capture m_rdata/m_rresp, go to RESP.
- RESP: rsp_valid[grant]=1 for 1 cycle with rsp_rdata/rsp_resp, then IDLE.
  - rsp_rdata/rsp_resp hold their value until the next RESP.
- Latency with a zero-wait slave:
  - Request sampled in cycle 0 → req_ready in cycle 1 → AW/W (or AR) valid in cycle 2.
  - rsp_valid arrives 2 cycles after the b/r handshake.
- Master channel valids never deassert before handshake; address/data are stable while valid.
- The master side never has more than one outstanding transaction.
- Requests arriving outside IDLE wait; req_valid dropping before grant is legal and is not granted.
- No timeout: a slave that never responds hangs the block until reset.
- rsp_resp is passed through unmodified (SLVERR/DECERR included).

Test Plan:
1. req0 write addr 0x500, wdata 0x12345678, wstrb 0xF, slave ready always → AW/W handshake 2 cycles after request; rsp_valid=01, rsp_resp=0, rsp_rdata=0.
2. req0 and req1 valid in the same cycle, both reads, repeated twice → grant order 0,1,0,1; rsp_valid pulses 01,10,01,10 with the correct per-address rdata.
3. Write with m_wready delayed 3 cycles after m_awready, then a second write with the order reversed → m_awvalid/m_wvalid each drop only after their own handshake; exactly one b handshake per write.
4. Read from addr 0x504, slave returns m_rdata=0xDEADBEEF, m_rresp=2'b10 → rsp_rdata=0xDEADBEEF, rsp_resp=2'b10 on the granted requester only.
5. Assert rst_main_n=0 while in WR_RESP with req1 pending → all outputs 0 immediately. After release the pointer restarts at 0, with no response for the aborted write and req1 served next.
